// File: rtl/gpu_isa_pkg.sv
// rtl/gpu_isa_pkg.sv - shared ISA encoding and sequencer state definitions
package gpu_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_END   = 4'd1,
    OP_XOR   = 4'd2,
    OP_ADDI  = 4'd3,
    OP_BGE   = 4'd4,
    OP_JUMP  = 4'd5,
    OP_BRT   = 4'd6,
    OP_ISSUE = 4'd7
  } opcode_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 24;
  localparam int IMM_MSB = 23;
  localparam int IMM_LSB = 14;
  localparam int RS_MSB  = 13;
  localparam int RS_LSB  = 10;
  localparam int RT_MSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int EXT_MSB = 5;
  localparam int EXT_LSB = 0;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE       = 2'd0;
  localparam seq_state_t ST_FILL       = 2'd1;
  localparam seq_state_t ST_EXEC       = 2'd2;
  localparam seq_state_t ST_ISSUE_WAIT = 2'd3;

endpackage

// File: rtl/instruction_sequencer_prog_mem.sv
// rtl/instruction_sequencer_prog_mem.sv - program store, one load port and one pipelined fetch port
// The read pipeline only moves when re is high, so a stalled sequencer keeps its in-flight words.
module instruction_sequencer_prog_mem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int LAT   = 2
) (
  input  logic          clk_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem  [DEPTH];
  logic [31:0] pipe [LAT];

  always_ff @(posedge clk_in) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (re) begin
      pipe[0] <= mem[raddr];
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rdata = pipe[LAT-1];

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetch/execute sequencer driving a downstream command port
// A prefetch pipeline tracks address and validity per stage alongside the memory read pipeline.
module instruction_sequencer
  import gpu_isa_pkg::*;
#(
  parameter int REG_WIDTH     = 10,
  parameter int REG_COUNT     = 16,
  parameter int INSTR_COUNT   = 512,
  parameter int FETCH_LATENCY = 2,
  localparam int PC_W         = $clog2(INSTR_COUNT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 prog_we_in,
  input  logic [PC_W-1:0]      prog_addr_in,
  input  logic [31:0]          prog_data_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [PC_W-1:0]      pc_out,
  output logic                 cmd_valid_out,
  input  logic                 cmd_ready_in,
  output logic [5:0]           cmd_tag_out,
  output logic [REG_WIDTH-1:0] cmd_data_out,
  input  logic [3:0]           dbg_sel_in,
  output logic [REG_WIDTH-1:0] dbg_reg_out
);

  localparam int LAT    = FETCH_LATENCY;
  localparam int FILL_W = $clog2(LAT + 1);

  seq_state_t           state;
  logic [PC_W-1:0]      fetch_pc;
  logic [PC_W-1:0]      fetch_next;
  logic [LAT-1:0]       pipe_v;
  logic [PC_W-1:0]      pipe_a [LAT];
  logic [FILL_W-1:0]    fill_cnt;
  logic                 cmp;
  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic [31:0]          head_word;
  logic [3:0]           op, rd, rs;
  logic [9:0]           imm;
  logic [5:0]           extra;
  logic [REG_WIDTH-1:0] rd_val, rs_val, imm_ext;
  logic [PC_W-1:0]      imm_pc;
  logic                 rd_ok, in_exec, head_v, is_issue, commit, advance, mem_we;
  logic                 unused_rt;

  function automatic logic [REG_WIDTH-1:0] reg_read(input logic [3:0] idx);
    return (int'(idx) < REG_COUNT) ? regs[idx] : '0;
  endfunction

  instruction_sequencer_prog_mem #(
    .DEPTH(INSTR_COUNT),
    .AW   (PC_W),
    .LAT  (LAT)
  ) u_prog_mem (
    .clk_in(clk_in),
    .we    (mem_we),
    .waddr (prog_addr_in),
    .wdata (prog_data_in),
    .re    (advance),
    .raddr (fetch_pc),
    .rdata (head_word)
  );

  assign op        = head_word[OP_MSB:OP_LSB];
  assign rd        = head_word[RD_MSB:RD_LSB];
  assign imm       = head_word[IMM_MSB:IMM_LSB];
  assign rs        = head_word[RS_MSB:RS_LSB];
  assign extra     = head_word[EXT_MSB:EXT_LSB];
  assign unused_rt = ^head_word[RT_MSB:RT_LSB];

  assign rd_val  = reg_read(rd);
  assign rs_val  = reg_read(rs);
  assign rd_ok   = int'(rd) < REG_COUNT;
  assign imm_ext = REG_WIDTH'(imm);
  assign imm_pc  = PC_W'(imm);

  // An ISSUE without ready holds the head slot and freezes the whole fetch pipeline.
  assign in_exec    = (state == ST_EXEC) || (state == ST_ISSUE_WAIT);
  assign head_v     = in_exec && pipe_v[LAT-1];
  assign is_issue   = head_v && (op == OP_ISSUE);
  assign commit     = head_v && (!is_issue || cmd_ready_in);
  assign advance    = (state == ST_FILL) || (in_exec && !(is_issue && !cmd_ready_in));
  assign fetch_next = (fetch_pc == PC_W'(INSTR_COUNT - 1)) ? '0 : fetch_pc + PC_W'(1);
  assign mem_we     = prog_we_in && (state == ST_IDLE);

  assign busy_out      = (state != ST_IDLE);
  assign cmd_valid_out = is_issue;
  assign cmd_tag_out   = extra;
  assign cmd_data_out  = rs_val;
  assign pc_out        = pipe_a[LAT-1];
  assign dbg_reg_out   = reg_read(dbg_sel_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      fetch_pc  <= '0;
      pipe_v    <= '0;
      fill_cnt  <= '0;
      cmp       <= 1'b0;
      done_out  <= 1'b0;
      error_out <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        pipe_a[i] <= '0;
      end
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_in) begin
            state    <= ST_FILL;
            fetch_pc <= '0;
            cmp      <= 1'b0;
            fill_cnt <= '0;
            pipe_v   <= '0;
          end
        end
        ST_FILL: begin
          if (fill_cnt == FILL_W'(LAT - 1)) begin
            state <= ST_EXEC;
          end
          fill_cnt <= fill_cnt + FILL_W'(1);
        end
        default: begin
          state <= (is_issue && !cmd_ready_in) ? ST_ISSUE_WAIT : ST_EXEC;
        end
      endcase

      if (advance) begin
        for (int i = LAT - 1; i > 0; i--) begin
          pipe_v[i] <= pipe_v[i-1];
          pipe_a[i] <= pipe_a[i-1];
        end
        pipe_v[0] <= 1'b1;
        pipe_a[0] <= fetch_pc;
        fetch_pc  <= fetch_next;
      end

      // Redirects and terminations override the sequential fetch above.
      if (commit) begin
        case (op)
          OP_END: begin
            state    <= ST_IDLE;
            done_out <= 1'b1;
            pipe_v   <= '0;
          end
          OP_XOR: begin
            if (rd_ok) regs[rd] <= rd_val ^ rs_val;
          end
          OP_ADDI: begin
            if (rd_ok) regs[rd] <= rs_val + imm_ext;
          end
          OP_BGE: cmp <= (rd_val >= rs_val);
          OP_JUMP: begin
            fetch_pc <= imm_pc;
            pipe_v   <= '0;
          end
          OP_BRT: begin
            if (cmp) begin
              fetch_pc <= imm_pc;
              pipe_v   <= '0;
            end
          end
          OP_NOP, OP_ISSUE: ;
          default: begin
            error_out <= 1'b1;
            state     <= ST_IDLE;
            pipe_v    <= '0;
          end
        endcase
      end
    end
  end

endmodule
